// File: rtl/pl_io_dev.sv
// pl_io_dev: board-side memory-mapped I/O device for the pipelined CPU.
//   Inputs to the CPU (inp0..inp3): debounced switches, key-press flags and
//   press counter with ack readback, prescaled timer, ID + display readback.
//   Outputs from the CPU (otp0..otp3): LEDs, key-flag ack/clear, timer clear,
//   hex display value.
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   otp0..otp3 [31:0]  CPU output words
//   sw [9:0]           raw slide switches (asynchronous)
//   key [3:0]          raw pushbuttons, active-low (asynchronous)
//   inp0..inp3 [31:0]  CPU input words
//   led [9:0]          registered otp0[9:0]
//   hex0..hex3 [6:0]   active-low 7-segment digits {g,f,e,d,c,b,a}
module pl_io_dev #(
  parameter int unsigned DB_CYCLES = 50000,
  parameter int unsigned PRESCALE  = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] otp0,
  input  logic [31:0] otp1,
  input  logic [31:0] otp2,
  input  logic [31:0] otp3,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [31:0] inp0,
  output logic [31:0] inp1,
  output logic [31:0] inp2,
  output logic [31:0] inp3,
  output logic [9:0]  led,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  localparam int unsigned DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam int unsigned NB = 14;

  // Switches and keys share one debounce datapath: bits [9:0] sw, [13:10] key.
  logic [NB-1:0]  sync1, sync2, db;
  logic [DBW-1:0] cnt [NB];

  logic [3:0]  key_prev;
  logic [3:0]  press;
  logic [3:0]  clr;
  logic [3:0]  flags;
  logic [7:0]  press_count;
  logic        ack_prev;
  logic        tclr_prev;
  logic [PSW-1:0] pre;
  logic [31:0] timer;
  logic [15:0] disp_reg;

  logic unused_bits;
  assign unused_bits = ^{otp0[31:10], otp1[30:4], otp2[30:0], otp3[31:16]};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= {4'hF, 10'h000};
      for (int unsigned i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {key, sw};
      sync2 <= sync1;
      for (int unsigned i = 0; i < NB; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DBW'(1);
        end
      end
    end
  end

  // A press is seen one cycle after the debounced key falls.
  assign press = key_prev & ~db[13:10];
  assign clr   = (otp1[31] != ack_prev) ? otp1[3:0] : 4'h0;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      key_prev    <= 4'hF;
      flags       <= '0;
      press_count <= '0;
      ack_prev    <= 1'b0;
    end else begin
      key_prev    <= db[13:10];
      flags       <= (flags & ~clr) | press;
      press_count <= press_count + 8'($countones(press));
      ack_prev    <= otp1[31];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pre       <= '0;
      timer     <= '0;
      tclr_prev <= 1'b0;
    end else begin
      tclr_prev <= otp2[31];
      if (otp2[31] != tclr_prev) begin
        pre   <= '0;
        timer <= '0;
      end else if (pre == PS_LAST) begin
        pre   <= '0;
        timer <= timer + 32'd1;
      end else begin
        pre <= pre + PSW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      led      <= '0;
      disp_reg <= '0;
    end else begin
      led      <= otp0[9:0];
      disp_reg <= otp3[15:0];
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    unique case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign inp0 = {22'b0, db[9:0]};
  assign inp1 = {ack_prev, 15'b0, press_count, 4'b0, flags};
  assign inp2 = timer;
  assign inp3 = {16'h1001, disp_reg};
  assign hex0 = seg7(disp_reg[3:0]);
  assign hex1 = seg7(disp_reg[7:4]);
  assign hex2 = seg7(disp_reg[11:8]);
  assign hex3 = seg7(disp_reg[15:12]);

endmodule
